// File: rtl/uart_pkg.sv
// Shared types and constants for the parametrised UART receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StBreak
    } rx_state_e;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_ODD  = 1;
    localparam int unsigned PAR_EVEN = 2;

    localparam int unsigned DATA_W_MIN = 5;
    localparam int unsigned DATA_W_MAX = 9;

    function automatic int unsigned bit_clks(input int unsigned clk_hz, input int unsigned baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Line synchroniser, free-running bit-period counter and 3-sample majority vote
// around the bit centre.
module uart_rx_sampler #(
    parameter int unsigned BIT_CLKS    = 434,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic rx_i,
    input  logic cnt_clr_i,
    output logic rxs_o,
    output logic sample_stb_o,
    output logic sample_bit_o
);

    localparam int unsigned MID   = BIT_CLKS / 2;
    localparam int unsigned CNT_W = $clog2(BIT_CLKS);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   early_q, mid_q;
    logic                   rxs;

    assign rxs   = sync_q[SYNC_STAGES-1];
    assign rxs_o = rxs;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_clr_i || cnt_q == CNT_W'(BIT_CLKS - 1)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q  <= '1;
            cnt_q   <= '0;
            early_q <= 1'b1;
            mid_q   <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
            cnt_q  <= cnt_d;
            if (cnt_q == CNT_W'(MID - 1)) early_q <= rxs;
            if (cnt_q == CNT_W'(MID))     mid_q   <= rxs;
        end
    end

    // Third vote is the live line value one count after the centre.
    assign sample_stb_o = !cnt_clr_i && (cnt_q == CNT_W'(MID + 1));
    assign sample_bit_o = (early_q & mid_q) | (early_q & rxs) | (mid_q & rxs);

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: frame FSM, shift and holding registers, sticky
// error flags and a valid/ready output handshake.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 50_000_000,
    parameter int unsigned BAUD        = 115_200,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned PARITY      = PAR_EVEN,
    parameter int unsigned STOP_BITS   = 1,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_i,
    output logic [DATA_W-1:0] rx_data_o,
    output logic              rx_valid_o,
    input  logic              rx_ready_i,
    output logic              parity_err_o,
    output logic              frame_err_o,
    output logic              overrun_o,
    input  logic              err_clr_i,
    output logic              busy_o
);

    localparam int unsigned BIT_CLKS  = bit_clks(CLK_HZ, BAUD);
    localparam longint      SHORTFALL = longint'(CLK_HZ) - longint'(BIT_CLKS) * longint'(BAUD);

    if (DATA_W < DATA_W_MIN || DATA_W > DATA_W_MAX) begin : g_chk_data_w
        $error("uart_rx_param: DATA_W must be 5..9");
    end
    if (PARITY > PAR_EVEN || STOP_BITS < 1 || STOP_BITS > 2 || SYNC_STAGES < 2) begin : g_chk_fmt
        $error("uart_rx_param: illegal PARITY, STOP_BITS or SYNC_STAGES");
    end
    // Truncation makes every bit short by the same fraction, so frame drift is this ratio.
    if (BIT_CLKS < 4 || SHORTFALL * 50 >= longint'(CLK_HZ)) begin : g_chk_baud
        $error("uart_rx_param: baud error from BIT_CLKS truncation is 2%% or more");
    end

    rx_state_e         state_q, state_d;
    logic [3:0]        idx_q, idx_d;
    logic [DATA_W-1:0] shift_q, shift_d, data_q, data_d;
    logic              par_q, par_d, par_bad_q, par_bad_d, frm_bad_q, frm_bad_d;
    logic              valid_q, valid_d, perr_q, perr_d, ferr_q, ferr_d, ovr_q, ovr_d;
    logic              rxs, sample_stb, sample_bit, deliver, frm_now, ovr_set;

    uart_rx_sampler #(
        .BIT_CLKS    (BIT_CLKS),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sampler (
        .clk          (clk),
        .rst          (rst),
        .rx_i         (rx_i),
        .cnt_clr_i    (state_q == StIdle),
        .rxs_o        (rxs),
        .sample_stb_o (sample_stb),
        .sample_bit_o (sample_bit)
    );

    assign frm_now = frm_bad_q | ~sample_bit;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        par_d     = par_q;
        par_bad_d = par_bad_q;
        frm_bad_d = frm_bad_q;
        deliver   = 1'b0;
        unique case (state_q)
            // Idle line is high, so a low synchronised line here is a falling edge.
            StIdle: if (!rxs) state_d = StStart;
            StStart: if (sample_stb) begin
                if (sample_bit) begin
                    state_d = StIdle;
                end else begin
                    state_d   = StData;
                    idx_d     = '0;
                    par_d     = 1'b0;
                    par_bad_d = 1'b0;
                    frm_bad_d = 1'b0;
                end
            end
            StData: if (sample_stb) begin
                shift_d = {sample_bit, shift_q[DATA_W-1:1]};
                par_d   = par_q ^ sample_bit;
                if (idx_q == 4'(DATA_W - 1)) begin
                    idx_d   = '0;
                    state_d = (PARITY == PAR_NONE) ? StStop : StParity;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
            StParity: if (sample_stb) begin
                par_bad_d = (PARITY == PAR_ODD) ? ~(par_q ^ sample_bit) : (par_q ^ sample_bit);
                state_d   = StStop;
            end
            StStop: if (sample_stb) begin
                frm_bad_d = frm_now;
                if (idx_q == 4'(STOP_BITS - 1)) begin
                    deliver = 1'b1;
                    state_d = frm_now ? StBreak : StIdle;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
            StBreak: if (rxs) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ovr_set = 1'b0;
        if (valid_q && rx_ready_i) valid_d = 1'b0;
        if (deliver) begin
            if (!valid_q || rx_ready_i) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                ovr_set = 1'b1;
            end
        end
        perr_d = (perr_q & ~err_clr_i) | (deliver & par_bad_q);
        ferr_d = (ferr_q & ~err_clr_i) | (deliver & frm_now);
        ovr_d  = (ovr_q & ~err_clr_i) | ovr_set;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            par_bad_q <= 1'b0;
            frm_bad_q <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            par_bad_q <= par_bad_d;
            frm_bad_q <= frm_bad_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
        end
    end

    assign rx_data_o    = data_q;
    assign rx_valid_o   = valid_q;
    assign parity_err_o = perr_q;
    assign frame_err_o  = ferr_q;
    assign overrun_o    = ovr_q;
    assign busy_o       = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: an EVEN/1-stop and an ODD/2-stop receiver share one
// line and are checked against a frame-level reference model.
`timescale 1ns/1ps
module tb_uart_rx_param;

    localparam int unsigned CLK_HZ = 1_000_000;
    localparam int unsigned BAUD   = 62_000;
    localparam int unsigned B      = CLK_HZ / BAUD;
    localparam int unsigned C      = B / 2;
    localparam int unsigned S      = 2;
    localparam int unsigned LAT_E  = S + 1 + (1 + 8 + 1 + 1 - 1) * B + C + 1;
    localparam int unsigned LAT_O  = S + 1 + (1 + 8 + 1 + 2 - 1) * B + C + 1;

    logic       clk = 1'b0, rst = 1'b0, rx = 1'b1, rx_ready = 1'b0, err_clr = 1'b0;
    logic [7:0] data_e, data_o;
    logic       valid_e, perr_e, ferr_e, ovr_e, busy_e;
    logic       valid_o, perr_o, ferr_o, ovr_o, busy_o;

    logic [7:0] m_data [2];
    logic       m_valid [2], m_perr [2], m_ferr [2], m_ovr [2];
    int         n_checks = 0, n_pass = 0, n_e, n_o;

    uart_rx_param #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_W(8), .PARITY(2), .STOP_BITS(1),
                    .SYNC_STAGES(S)) u_even (
        .clk(clk), .rst(rst), .rx_i(rx), .rx_data_o(data_e), .rx_valid_o(valid_e),
        .rx_ready_i(rx_ready), .parity_err_o(perr_e), .frame_err_o(ferr_e),
        .overrun_o(ovr_e), .err_clr_i(err_clr), .busy_o(busy_e)
    );

    uart_rx_param #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_W(8), .PARITY(1), .STOP_BITS(2),
                    .SYNC_STAGES(S)) u_odd (
        .clk(clk), .rst(rst), .rx_i(rx), .rx_data_o(data_o), .rx_valid_o(valid_o),
        .rx_ready_i(rx_ready), .parity_err_o(perr_o), .frame_err_o(ferr_o),
        .overrun_o(ovr_o), .err_clr_i(err_clr), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic check_all(input string tag);
        check($sformatf("%s.even.data", tag), 32'(data_e), 32'(m_data[0]));
        check($sformatf("%s.even.valid", tag), 32'(valid_e), 32'(m_valid[0]));
        check($sformatf("%s.even.perr", tag), 32'(perr_e), 32'(m_perr[0]));
        check($sformatf("%s.even.ferr", tag), 32'(ferr_e), 32'(m_ferr[0]));
        check($sformatf("%s.even.ovr", tag), 32'(ovr_e), 32'(m_ovr[0]));
        check($sformatf("%s.even.busy", tag), 32'(busy_e), 32'd0);
        check($sformatf("%s.odd.data", tag), 32'(data_o), 32'(m_data[1]));
        check($sformatf("%s.odd.valid", tag), 32'(valid_o), 32'(m_valid[1]));
        check($sformatf("%s.odd.perr", tag), 32'(perr_o), 32'(m_perr[1]));
        check($sformatf("%s.odd.ferr", tag), 32'(ferr_o), 32'(m_ferr[1]));
        check($sformatf("%s.odd.ovr", tag), 32'(ovr_o), 32'(m_ovr[1]));
        check($sformatf("%s.odd.busy", tag), 32'(busy_o), 32'd0);
    endtask

    // Frame-level reference: receiver 0 is EVEN/1 stop, receiver 1 is ODD/2 stop.
    task automatic model_frame(input logic [7:0] d, input logic p, input logic s1,
                               input logic s2);
        for (int i = 0; i < 2; i++) begin
            logic ones_odd, pbad, fbad;
            ones_odd = ^{d, p};
            pbad = (i == 0) ? ones_odd : !ones_odd;
            fbad = (i == 0) ? !s1 : (!s1 || !s2);
            if (m_valid[i]) m_ovr[i] = 1'b1;
            else begin
                m_data[i]  = d;
                m_valid[i] = 1'b1;
            end
            m_perr[i] = m_perr[i] | pbad;
            m_ferr[i] = m_ferr[i] | fbad;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_data[i] = '0; m_valid[i] = 0; m_perr[i] = 0; m_ferr[i] = 0; m_ovr[i] = 0;
        end
    endtask

    function automatic logic [11:0] build(input logic [7:0] d, input logic p, input logic s1);
        return {1'b1, s1, p, d, 1'b0};
    endfunction

    // Called on a falling clock edge; each line bit lasts B clocks, optional one-clock
    // inverted spike centred in the majority window of bit 'spike'.
    task automatic send_line(input logic [11:0] line, input int nbits, input int spike);
        for (int j = 0; j < nbits; j++) begin
            rx = line[j];
            if (j == spike) begin
                repeat (C + 1) @(negedge clk);
                rx = ~line[j];
                @(negedge clk);
                rx = line[j];
                repeat (B - C - 2) @(negedge clk);
            end else begin
                repeat (B) @(negedge clk);
            end
        end
    endtask

    task automatic run_frame(input string tag, input logic [7:0] d, input logic p,
                             input logic s1, input int spike);
        send_line(build(d, p, s1), 12, spike);
        rx = 1'b1;
        repeat (2 * B) @(negedge clk);
        model_frame(d, p, s1, 1'b1);
        check_all(tag);
    endtask

    task automatic read_pulse();
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        m_valid[0] = 0; m_valid[1] = 0;
    endtask

    task automatic clear_pulse();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_perr[i] = 0; m_ferr[i] = 0; m_ovr[i] = 0;
        end
    endtask

    initial begin
        logic [7:0] d;
        logic       p, s1;
        int         spike;
        model_reset();
        repeat (3) @(negedge clk);
        check_all("reset");
        rst = 1'b1;
        repeat (4) @(negedge clk);

        // Clean frame, with start-edge to rx_valid latency measured on both receivers.
        fork
            send_line(build(8'h0C, 1'b0, 1'b1), 12, -1);
            begin
                n_e = 0;
                while (valid_e !== 1'b1 && n_e < 400) begin @(negedge clk); n_e++; end
            end
            begin
                n_o = 0;
                while (valid_o !== 1'b1 && n_o < 400) begin @(negedge clk); n_o++; end
            end
        join
        rx = 1'b1;
        repeat (2 * B) @(negedge clk);
        check("lat.even", 32'(n_e - 1), 32'(LAT_E));
        check("lat.odd", 32'(n_o - 1), 32'(LAT_O));
        model_frame(8'h0C, 1'b0, 1'b1, 1'b1);
        check_all("f0C");

        run_frame("ovr08", 8'h08, 1'b1, 1'b1, -1);
        clear_pulse();
        check_all("clr");

        read_pulse();
        run_frame("parAA", 8'hAA, 1'b1, 1'b1, -1);

        // Holding register read in the very cycle a new character lands.
        clear_pulse();
        fork
            send_line(build(8'h5A, 1'b0, 1'b1), 12, -1);
            begin
                repeat (LAT_E) @(negedge clk);
                rx_ready = 1'b1;
                @(negedge clk);
                rx_ready = 1'b0;
            end
        join
        rx = 1'b1;
        repeat (2 * B) @(negedge clk);
        m_valid[0] = 0; m_valid[1] = 0;
        model_frame(8'h5A, 1'b0, 1'b1, 1'b1);
        check_all("samecyc");

        read_pulse();
        clear_pulse();
        rx = 1'b0;
        repeat (5) @(negedge clk);
        rx = 1'b1;
        repeat (2 * B) @(negedge clk);
        check_all("glitch");

        // Line break: stop bit held low for three bit-times.
        send_line(build(8'h55, 1'b0, 1'b0), 11, -1);
        rx = 1'b0;
        repeat (B + C) @(negedge clk);
        check("brk.even.busy", 32'(busy_e), 32'd1);
        check("brk.odd.busy", 32'(busy_o), 32'd1);
        repeat (B - C) @(negedge clk);
        rx = 1'b1;
        repeat (B) @(negedge clk);
        model_frame(8'h55, 1'b0, 1'b0, 1'b0);
        check_all("brk55");
        read_pulse();
        run_frame("after_brk", 8'h12, 1'b0, 1'b1, -1);

        read_pulse();
        clear_pulse();
        run_frame("spike", 8'hA1, 1'b1, 1'b1, 4);

        // Reset in the middle of data bit 4.
        send_line(build(8'hF0, 1'b0, 1'b1), 5, -1);
        rx = 1'b1;
        repeat (C) @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        check_all("rst_mid");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        run_frame("f3C", 8'h3C, 1'b0, 1'b1, -1);

        for (int k = 0; k < 16; k++) begin
            if ($urandom_range(1) == 1) read_pulse();
            if ($urandom_range(3) == 0) clear_pulse();
            d     = 8'($urandom);
            p     = 1'($urandom_range(1));
            s1    = ($urandom_range(3) != 0);
            spike = ($urandom_range(1) == 1) ? int'($urandom_range(8, 1)) : -1;
            run_frame($sformatf("rnd%0d", k), d, p, s1, spike);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
